// File: rtl/ubus_arb_pkg.sv
// Shared types and constants for the UBUS round-robin arbiter.
// The optional data-phase timeout is enabled by defining UBUS_ARB_TIMEOUT_EN.
package ubus_arb_pkg;

    localparam int UBUS_ARB_MAX_MASTERS = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        NOOP  = 3'd2,
        ADDR  = 3'd3,
        DATA  = 3'd4
    } ubus_arb_state_e;

    // Index that follows idx in a ring of n entries
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/ubus_rr_picker.sv
// Combinational rotating-priority picker: first requester at or after i_ptr,
// searching upward with wrap-around.
module ubus_rr_picker
    import ubus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         i_req,
    input  logic [$clog2(NUM_MASTERS)-1:0] i_ptr,
    output logic [NUM_MASTERS-1:0]         o_gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] o_idx,
    output logic                           o_valid
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] w_gnt;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_valid;
    logic                   w_hit;
    int                     w_k;

    // Scan the ring starting at the pointer; the first hit wins
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_valid = 1'b0;
        w_hit   = 1'b0;
        w_k     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_k        = int'(i_ptr) + i;
            w_k        = (w_k >= NUM_MASTERS) ? (w_k - NUM_MASTERS) : w_k;
            w_hit      = !w_valid && i_req[w_k];
            w_gnt[w_k] = w_hit;
            w_idx      = w_hit ? IDX_W'(w_k) : w_idx;
            w_valid    = w_valid | w_hit;
        end
    end

    assign o_gnt   = w_gnt;
    assign o_idx   = w_idx;
    assign o_valid = w_valid;

endmodule

// File: rtl/ubus_rr_arbiter.sv
// UBUS central arbiter and phase sequencer with round-robin grants.
// Define UBUS_ARB_TIMEOUT_EN to build the MAX_WAIT data-phase timeout.
module ubus_rr_arbiter
    import ubus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_WAIT    = 16
) (
    input  logic                           ubus_clock,
    input  logic                           ubus_reset_n,
    input  logic [NUM_MASTERS-1:0]         ubus_req,
    output logic [NUM_MASTERS-1:0]         ubus_gnt,
    output logic                           ubus_start,
    output logic                           ubus_read,
    output logic                           ubus_write,
    input  logic                           ubus_bip,
    input  logic                           ubus_wait,
    input  logic                           ubus_error,
    output logic [$clog2(NUM_MASTERS)-1:0] arb_gnt_id,
    output logic                           arb_timeout
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    ubus_arb_state_e        r_state;
    ubus_arb_state_e        w_next;
    logic                   r_start;
    logic                   r_noop;
    logic                   r_timeout;
    logic                   w_timeout;
    logic                   w_data_done;
    logic                   w_to_hit;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [IDX_W-1:0]       r_gnt_id;
    logic [IDX_W-1:0]       r_ptr;
    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_ptr_next;

    ubus_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .i_req   (ubus_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_ptr_next  = IDX_W'(rr_next(int'(w_pick_idx), NUM_MASTERS));
    // error wins over wait; a dropped request never ends the data phase
    assign w_data_done = ubus_error || (!ubus_bip && !ubus_wait);

`ifdef UBUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Counts completed DATA cycles; cleared in ADDR, just before DATA entry
    always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
        if (!ubus_reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ADDR) begin
            r_wait_cnt <= '0;
        end else if ((r_state == DATA) && (r_wait_cnt != CNT_W'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    assign w_to_hit = (r_wait_cnt == CNT_W'(MAX_WAIT - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    // Phase state register
    always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
        if (!ubus_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-phase decode
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:  w_next = START;
            START: w_next = (|r_gnt) ? ADDR : NOOP;
            NOOP:  w_next = START;
            ADDR:  w_next = DATA;
            DATA: begin
                if (w_data_done) begin
                    w_next = START;
                end else if (w_to_hit) begin
                    w_next    = START;
                    w_timeout = 1'b1;
                end else begin
                    w_next = DATA;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Phase-qualified outputs registered alongside the state
    always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
        if (!ubus_reset_n) begin
            r_start   <= 1'b0;
            r_noop    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start   <= (w_next == START);
            r_noop    <= (w_next == NOOP);
            r_timeout <= w_timeout;
        end
    end

    // Grants and rotating pointer update on the falling edge inside START
    always_ff @(negedge ubus_clock or negedge ubus_reset_n) begin
        if (!ubus_reset_n) begin
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
        end else if (r_start && w_pick_valid) begin
            r_gnt    <= w_pick_gnt;
            r_gnt_id <= w_pick_idx;
            r_ptr    <= w_ptr_next;
        end else begin
            r_gnt    <= '0;
            r_gnt_id <= r_gnt_id;
            r_ptr    <= r_ptr;
        end
    end

    assign ubus_gnt    = r_gnt;
    assign ubus_start  = r_start;
    assign arb_gnt_id  = r_gnt_id;
    assign arb_timeout = r_timeout;
    assign ubus_read   = r_noop ? 1'b0 : 1'bz;
    assign ubus_write  = r_noop ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ubus_rr_arbiter.sv
// Directed bench for ubus_rr_arbiter (4 masters, MAX_WAIT=4); checks the
// timeout path when UBUS_ARB_TIMEOUT_EN is defined, the unbounded DATA otherwise.
module tb_ubus_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       start;
    wire        w_read;
    wire        w_write;
    logic       bip;
    logic       wt;
    logic       err;
    logic [1:0] gnt_id;
    logic       timeout;
    int         n_assert = 0;
    int         n_fail   = 0;

    // released read/write strobes read back as 1 through the pull-ups
    pullup (w_read);
    pullup (w_write);

    ubus_rr_arbiter #(
        .NUM_MASTERS (4),
        .MAX_WAIT    (4)
    ) dut (
        .ubus_clock   (clk),
        .ubus_reset_n (rst_n),
        .ubus_req     (req),
        .ubus_gnt     (gnt),
        .ubus_start   (start),
        .ubus_read    (w_read),
        .ubus_write   (w_write),
        .ubus_bip     (bip),
        .ubus_wait    (wt),
        .ubus_error   (err),
        .arb_gnt_id   (gnt_id),
        .arb_timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic half();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    logic [1:0] exp_id  [4] = '{2'd0, 2'd1, 2'd0, 2'd1};

    initial begin
        rst_n = 1'b0; req = 4'b0000; bip = 1'b0; wt = 1'b0; err = 1'b0;
        #1;
        check("rst_start", start, 1'b0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_id", gnt_id, 2'd0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_read", w_read, 1'b1);
        check("rst_write", w_write, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle bus: START / NOOP alternate
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_start", start, 1'b1);
            check("idle_read_z", w_read, 1'b1);
            half();
            check("idle_gnt", gnt, 4'b0000);
            tick();
            check("noop_start", start, 1'b0);
            check("noop_read", w_read, 1'b0);
            check("noop_write", w_write, 1'b0);
        end

        // Two contenders alternate with single-beat transfers
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_start", start, 1'b1);
            half();
            check("rr_gnt", gnt, exp_gnt[i]);
            check("rr_id", gnt_id, exp_id[i]);
            tick();
            check("addr_start", start, 1'b0);
            check("addr_read_z", w_read, 1'b1);
            tick();
            check("data_start", start, 1'b0);
        end

        // Pointer now at 2: masters 1 and 3 request -> 3 first, then wrap to 1
        req = 4'b1010;
        tick();
        half();
        check("wrap_gnt3", gnt, 4'b1000);
        check("wrap_id3", gnt_id, 2'd3);
        tick();
        tick();
        tick();
        half();
        check("wrap_gnt1", gnt, 4'b0010);
        check("wrap_id1", gnt_id, 2'd1);

        // Request drops; bip 3 cycles, wait 2 cycles, then release
        req = 4'b0000;
        bip = 1'b1;
        tick();
        check("ph_addr", start, 1'b0);
        for (int d = 1; d <= 6; d++) begin
            tick();
            check("ph_data", start, 1'b0);
            if (d == 4) begin
                bip = 1'b0;
                wt  = 1'b1;
            end
            if (d == 6) begin
                wt = 1'b0;
            end
        end
        tick();
        check("ph_start_after6", start, 1'b1);

        // Error overrides wait
        req = 4'b0100;
        half();
        check("err_gnt", gnt, 4'b0100);
        check("err_id", gnt_id, 2'd2);
        req = 4'b0000;
        wt  = 1'b1;
        tick();
        tick();
        check("err_data", start, 1'b0);
        err = 1'b1;
        tick();
        check("err_start", start, 1'b1);
        err = 1'b0;
        wt  = 1'b0;
        half();
        check("noreq_gnt", gnt, 4'b0000);
        check("noreq_id_hold", gnt_id, 2'd2);
        tick();
        check("noreq_noop", w_read, 1'b0);

        // Pointer held at 3: search 3,0,1 -> master 1
        req = 4'b0110;
        tick();
        half();
        check("hold_gnt", gnt, 4'b0010);
        check("hold_id", gnt_id, 2'd1);

        // Reset in DATA aborts asynchronously and restarts the pointer
        req = 4'b0000;
        bip = 1'b1;
        tick();
        tick();
        check("pre_rst_data", start, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_start", start, 1'b0);
        check("arst_gnt", gnt, 4'b0000);
        check("arst_id", gnt_id, 2'd0);
        check("arst_read", w_read, 1'b1);
        check("arst_timeout", timeout, 1'b0);
        bip = 1'b0;
        tick();
        check("rst_hold_start", start, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_start", start, 1'b1);
        req = 4'b0110;
        half();
        check("post_rst_gnt", gnt, 4'b0010);
        check("post_rst_id", gnt_id, 2'd1);

        // Long wait: bounded by the timeout only when it is built
        req = 4'b0000;
        wt  = 1'b1;
        tick();
        for (int d = 1; d <= 4; d++) begin
            tick();
            check("to_data", start, 1'b0);
            check("to_quiet", timeout, 1'b0);
        end
`ifdef UBUS_ARB_TIMEOUT_EN
        tick();
        check("to_start", start, 1'b1);
        check("to_pulse", timeout, 1'b1);
        wt = 1'b0;
        tick();
        check("to_pulse_end", timeout, 1'b0);
        check("to_noop", start, 1'b0);
`else
        tick();
        check("nto_data5", start, 1'b0);
        check("nto_flag5", timeout, 1'b0);
        tick();
        check("nto_data6", start, 1'b0);
        wt = 1'b0;
        tick();
        check("nto_start", start, 1'b1);
        check("nto_flag", timeout, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
